func_int_muldiv: RTL

Iterative RV64/RV32 M-extension unit for the core's integer execute stage, parametrised in XLEN. It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus the word variants (MULW, DIVW, DIVUW, REMW, REMUW) when XLEN=64. It sits beside the single-cycle integer ALU and completes one product or quotient bit per cycle. Operands arrive and results leave over valid/ready handshakes, so execute can stall around it.

---
 rtl/func_int_muldiv_if.sv | 25 ++
 rtl/func_int_muldiv.sv | 129 ++++++++++++
 2 files changed

// File: rtl/func_int_muldiv_if.sv
// Operand/result handshake bundle for the iterative M-extension unit.
// Master is the execute stage; slave is the mul/div unit.
interface func_int_muldiv_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic            is_word;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_idx;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [4:0]      out_rd_idx;

    modport master (
        output in_valid, funct3, is_word, rs1, rs2, rd_idx, out_ready,
        input  in_ready, out_valid, out_data, out_rd_idx
    );

    modport slave (
        input  in_valid, funct3, is_word, rs1, rs2, rd_idx, out_ready,
        output in_ready, out_valid, out_data, out_rd_idx
    );
endinterface

// File: rtl/func_int_muldiv.sv
// Iterative RV M-extension unit: one product/quotient bit per cycle, N+1 cycles (N=32/64), 1 cycle for div special cases.
// Single operation in flight; result held stable until out_ready, flush kills anything pending.
module func_int_muldiv #(
    parameter int XLEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    func_int_muldiv_if.slave io
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam bit HAS_W = (XLEN == 64);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'(signed'(v));
    endfunction

    state_t            state_q, state_d;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   mq_q, opa_q, out_data_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic              word_q, a_neg_q, b_neg_q;
    logic [4:0]        out_rd_q;

    // Operand decode at accept time
    logic            word, is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] op_a, op_b, a_mag, b_mag, src_mq;
    logic            div_zero, div_ovf, special, accept, busy;
    logic [XLEN-1:0] spec_raw, spec_res;

    assign word   = HAS_W && io.is_word;
    assign is_div = io.funct3[2];
    assign a_sgn  = is_div ? !io.funct3[0] : (io.funct3[1:0] == 2'b01 || io.funct3[1:0] == 2'b10);
    assign b_sgn  = is_div ? !io.funct3[0] : (io.funct3[1:0] == 2'b01);
    assign op_a   = word ? (a_sgn ? sext32(io.rs1[31:0]) : XLEN'(io.rs1[31:0])) : io.rs1;
    assign op_b   = word ? (b_sgn ? sext32(io.rs2[31:0]) : XLEN'(io.rs2[31:0])) : io.rs2;
    assign a_neg  = a_sgn && op_a[XLEN-1];
    assign b_neg  = b_sgn && op_b[XLEN-1];
    assign a_mag  = a_neg ? -op_a : op_a;
    assign b_mag  = b_neg ? -op_b : op_b;
    assign src_mq = is_div ? a_mag : b_mag;

    assign div_zero = is_div && (op_b == '0);
    assign div_ovf  = is_div && !io.funct3[0] && (op_b == '1) &&
                      (op_a == (word ? sext32(32'h8000_0000) : MIN_X));
    assign special  = div_zero || div_ovf;
    assign spec_raw = div_zero ? (io.funct3[1] ? op_a : '1) : (io.funct3[1] ? '0 : op_a);
    assign spec_res = word ? sext32(spec_raw[31:0]) : spec_raw;

    assign io.in_ready   = (state_q == S_IDLE) && !flush;
    assign io.out_valid  = (state_q == S_DONE);
    assign io.out_data   = out_data_q;
    assign io.out_rd_idx = out_rd_q;
    assign accept        = io.in_valid && io.in_ready;
    assign busy          = (state_q == S_MUL) || (state_q == S_DIV);

    // One iteration step; word ops pre-shift their operand so the MSB-first walk works for both widths
    logic [XLEN-1:0]   addend;
    logic [2*XLEN-1:0] mul_acc, step_acc, prod;
    logic [XLEN:0]     shifted, rem_w;
    logic [XLEN+1:0]   diff;
    logic [XLEN-1:0]   step_mq, quo, rmd, fin_raw, fin_res;

    assign addend   = mq_q[XLEN-1] ? opa_q : '0;
    assign mul_acc  = (acc_q << 1) + {{XLEN{1'b0}}, addend};
    assign shifted  = {acc_q[XLEN-1:0], mq_q[XLEN-1]};
    assign diff     = {1'b0, shifted} - {2'b00, opa_q};
    assign rem_w    = diff[XLEN+1] ? shifted : diff[XLEN:0];
    assign step_acc = (state_q == S_MUL) ? mul_acc : {{(XLEN-1){1'b0}}, rem_w};
    assign step_mq  = (state_q == S_MUL) ? (mq_q << 1) : {mq_q[XLEN-2:0], !diff[XLEN+1]};

    assign prod    = (a_neg_q ^ b_neg_q) ? -step_acc : step_acc;
    assign quo     = (a_neg_q ^ b_neg_q) ? -step_mq : step_mq;
    assign rmd     = a_neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    assign fin_raw = !f3_q[2] ? ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                              : (f3_q[1] ? rmd : quo);
    assign fin_res = word_q ? sext32(fin_raw[31:0]) : fin_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (accept) state_d = special ? S_DONE : (is_div ? S_DIV : S_MUL);
            S_MUL, S_DIV: if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:       if (io.out_ready) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            mq_q       <= '0;
            opa_q      <= '0;
            cnt_q      <= '0;
            f3_q       <= '0;
            word_q     <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            out_data_q <= '0;
            out_rd_q   <= '0;
        end else if (accept) begin
            acc_q    <= '0;
            mq_q     <= word ? (src_mq << (XLEN/2)) : src_mq;
            opa_q    <= is_div ? b_mag : a_mag;
            cnt_q    <= word ? CW'(32) : CW'(XLEN);
            f3_q     <= io.funct3;
            word_q   <= word;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            out_rd_q <= io.rd_idx;
            if (special) out_data_q <= spec_res;
        end else if (busy && !flush) begin
            acc_q <= step_acc;
            mq_q  <= step_mq;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) out_data_q <= fin_res;
        end
    end
endmodule
